// File: rtl/heap_level_ram_if.sv
// heap_level_ram_if
//   Bus bundle for one heap-level RAM: the clear request, the ready and
//   collision status lines, and both read/write ports.
//   master : sort controller side (drives clear, data_x, we_x, addr_x)
//   slave  : RAM side (drives ready, collision, q_x)
//   Parameters DATA_WIDTH / ADDR_WIDTH must match the attached RAM.
interface heap_level_ram_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
);
    logic                  clear;
    logic                  ready;
    logic                  collision;
    logic [DATA_WIDTH-1:0] data_a;
    logic                  we_a;
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [DATA_WIDTH-1:0] q_a;
    logic [DATA_WIDTH-1:0] data_b;
    logic                  we_b;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic [DATA_WIDTH-1:0] q_b;

    modport master (
        output clear, data_a, we_a, addr_a, data_b, we_b, addr_b,
        input  ready, collision, q_a, q_b
    );

    modport slave (
        input  clear, data_a, we_a, addr_a, data_b, we_b, addr_b,
        output ready, collision, q_a, q_b
    );
endinterface

// File: rtl/heap_level_ram.sv
// heap_level_ram
//   True dual-port RAM holding one heap level (DEPTH = 1 << LEVEL words).
//   After reset, or on a clear request, a sweep fills every word with
//   CLEAR_VALUE; ready goes high once the sweep is finished and port traffic
//   is accepted from then on. Both ports writing the same word resolve in
//   favour of port A and raise a one-cycle collision pulse.
//
//   Ports:
//     clk    - clock, all state on the rising edge
//     rst_n  - asynchronous active-low reset
//     bus    - heap_level_ram_if.slave: clear, ready, collision,
//              data_a/we_a/addr_a/q_a, data_b/we_b/addr_b/q_b
//
//   Parameters:
//     DATA_WIDTH  word width
//     ADDR_WIDTH  address width (>= LEVEL, only addr[LEVEL-1:0] used)
//     LEVEL       heap level; LEVEL=0 is a single-word register
//     CLEAR_VALUE sentinel written by the sweep
//     READ_MODE   0 = read-first, 1 = write-first
//
//   Optional macro HEAP_RAM_OUTREG_EN: adds an output register stage on
//   q_a, q_b and collision (read latency 2); ready is not delayed.
module heap_level_ram #(
    parameter int unsigned            DATA_WIDTH  = 32,
    parameter int unsigned            ADDR_WIDTH  = 5,
    parameter int unsigned            LEVEL       = 1,
    parameter logic [DATA_WIDTH-1:0]  CLEAR_VALUE = '1,
    parameter int unsigned            READ_MODE   = 0
) (
    input logic               clk,
    input logic               rst_n,
    heap_level_ram_if.slave   bus
);

    localparam int unsigned            DEPTH     = 1 << LEVEL;
    localparam int unsigned            IDX_W     = (LEVEL > 0) ? LEVEL : 1;
    localparam logic [ADDR_WIDTH-1:0]  ADDR_MASK = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [IDX_W-1:0]       LAST_IDX  = IDX_W'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      cnt_q, cnt_d;
    logic                  ready_q;

    logic [IDX_W-1:0]      idx_a, idx_b;
    logic                  wr_a, wr_b, col_d;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_a, rd_b;
    logic [DATA_WIDTH-1:0] q_a_q, q_b_q;
    logic                  col_q;

    // Masking rather than slicing keeps LEVEL=0 legal: the index collapses
    // to 0 and every access hits the single word.
    assign idx_a = IDX_W'(bus.addr_a & ADDR_MASK);
    assign idx_b = IDX_W'(bus.addr_b & ADDR_MASK);

    // ---------------- sweep FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            // ready trails the state by one edge on the way up but drops on
            // the same edge that samples clear.
            ready_q <= (state_q == ST_READY) && !bus.clear;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_CLEAR: begin
                if (bus.clear) begin
                    cnt_d = '0;
                end else if (cnt_q == LAST_IDX) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_READY: begin
                if (bus.clear) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    // ---------------- port qualification ----------------
    // ready_q is only high while the sweep is idle, so sweep writes and port
    // writes never coincide.
    assign wr_a  = ready_q && !bus.clear && bus.we_a;
    assign wr_b  = ready_q && !bus.clear && bus.we_b;
    assign col_d = wr_a && wr_b && (idx_a == idx_b);

    // ---------------- storage (not reset) ----------------
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            mem[cnt_q] <= CLEAR_VALUE;
        end else begin
            // Port A is written last so it wins a same-address collision.
            if (wr_b) begin
                mem[idx_b] <= bus.data_b;
            end
            if (wr_a) begin
                mem[idx_a] <= bus.data_a;
            end
        end
    end

    // ---------------- read path ----------------
    always_comb begin
        rd_a = mem[idx_a];
        rd_b = mem[idx_b];
        if (READ_MODE != 0) begin
            // Write-first: show the word that ends up stored, with port A
            // taking precedence.
            if (wr_a) begin
                rd_a = bus.data_a;
            end else if (wr_b && (idx_b == idx_a)) begin
                rd_a = bus.data_b;
            end
            if (wr_a && (idx_a == idx_b)) begin
                rd_b = bus.data_a;
            end else if (wr_b) begin
                rd_b = bus.data_b;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_a_q <= '0;
            q_b_q <= '0;
            col_q <= 1'b0;
        end else if (ready_q) begin
            q_a_q <= rd_a;
            q_b_q <= rd_b;
            col_q <= col_d;
        end else begin
            q_a_q <= CLEAR_VALUE;
            q_b_q <= CLEAR_VALUE;
            col_q <= 1'b0;
        end
    end

`ifdef HEAP_RAM_OUTREG_EN
    logic [DATA_WIDTH-1:0] q_a_o, q_b_o;
    logic                  col_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_a_o <= '0;
            q_b_o <= '0;
            col_o <= 1'b0;
        end else begin
            q_a_o <= q_a_q;
            q_b_o <= q_b_q;
            col_o <= col_q;
        end
    end

    assign bus.q_a       = q_a_o;
    assign bus.q_b       = q_b_o;
    assign bus.collision = col_o;
`else
    assign bus.q_a       = q_a_q;
    assign bus.q_b       = q_b_q;
    assign bus.collision = col_q;
`endif

    assign bus.ready = ready_q;

endmodule

// File: doc/heap_level_ram.md
Name: heap_level_ram

Overview:
- Parametrised true dual-port RAM for one heap level, successor to the per-level level RAM in the heap sorter.
- Adds selectable read-during-write mode and deterministic collision resolution with a collision flag.
- Adds a self-clearing sweep FSM that fills the level with a sentinel after reset or on request.
- The sort controller waits on ready before starting insert/extract traffic.

Parameters:
- DATA_WIDTH, 32, word width in bits.
- ADDR_WIDTH, 5, address port width; must be >= LEVEL; only addr[LEVEL-1:0] is used, upper bits are ignored.
- LEVEL, 1, heap level; DEPTH = 1<<LEVEL words; LEVEL=0 gives a single-word register implementation.
- CLEAR_VALUE, {DATA_WIDTH{1'b1}}, sentinel written by the clear sweep (max value = empty slot).
- READ_MODE, 0, 0 = read-first (q shows the old word), 1 = write-first (q shows the final stored word).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous request to re-run the clear sweep.
- ready  out  1  high when the sweep is done and port traffic is accepted.
- collision  out  1  one-cycle pulse: both ports wrote the same address in the previous cycle.
- data_a  in  DATA_WIDTH  port A write data.
- we_a  in  1  port A write enable.
- addr_a  in  ADDR_WIDTH  port A address.
- q_a  out  DATA_WIDTH  port A read data.
- data_b  in  DATA_WIDTH  port B write data.
- we_b  in  1  port B write enable.
- addr_b  in  ADDR_WIDTH  port B address.
- q_b  out  DATA_WIDTH  port B read data.

Behaviour:
- Reset (rst_n low, asynchronous): q_a = q_b = 0, ready = 0, collision = 0, FSM = CLEAR, sweep counter = 0.
- Memory array is not reset; the sweep initialises it.
- FSM states:
  - CLEAR: writes CLEAR_VALUE to word cnt each cycle, cnt++.
    - Leaves after the write of word DEPTH-1 -> READY.
    - DEPTH cycles total; ready rises on the following edge.
  - READY: normal dual-port operation.
    - clear=1 -> CLEAR with cnt=0; ready drops on the next edge.
- clear asserted during CLEAR restarts the sweep at cnt=0.
- Reset mid-sweep restarts the sweep from 0.
- While ready=0:
  - we_a/we_b are ignored.
  - q_a/q_b are driven to CLEAR_VALUE, registered.
  - collision stays 0.
- Read latency is 1 cycle: q_x at edge N+1 reflects addr_x sampled at edge N.
- Same-port write:
  - READ_MODE=0: q_x = old word.
  - READ_MODE=1: q_x = the word actually stored (see collision rule).
- Cross-port, A writes and B reads the same address (symmetric for B writes / A reads):
  - READ_MODE=0: q_b = old word.
  - READ_MODE=1: q_b = data_a (forwarded).
- Both ports write the same address:
  - Port A wins; the stored word is data_a.
  - collision = 1 on the next edge for exactly one cycle.
  - READ_MODE=1: both q_a and q_b = data_a.
- LEVEL=0: a single register holds the word; addresses are ignored; every access is a same-address access; the rules above apply unchanged.
- clear has priority over simultaneous writes in READY: the writes in that cycle are dropped.

Optional Feature:
- Macro HEAP_RAM_OUTREG_EN.
- Defined:
  - An extra output register stage is added on q_a, q_b and collision; read latency becomes 2 cycles.
  - The output stage resets to 0.
  - While ready=0 the stage still shows CLEAR_VALUE, one cycle delayed.
  - ready itself is not delayed.
- Undefined: 1-cycle latency as specified above.

Test Plan:
- LEVEL=3, release rst_n -> ready low for 8 cycles, high on the 9th edge; read of addr 0..7 returns 0xFFFFFFFF each.
- Write A addr 2 = 0x11, then next cycle read B addr 2 -> q_b = 0x11 one cycle later (two with HEAP_RAM_OUTREG_EN).
- READ_MODE=0, addr 5 holds 0xAA; A writes 0xBB to 5 while B reads 5 -> q_b = 0xAA; next read = 0xBB. Repeat with READ_MODE=1 -> q_b = 0xBB immediately.
- Both ports write addr 4 (A = 0x1, B = 0x2) -> collision pulses one cycle; subsequent read of addr 4 = 0x1.
- Assert clear in READY with we_a=1 to addr 1 -> write dropped, ready low for 8 cycles, addr 1 reads 0xFFFFFFFF. Assert rst_n low mid-sweep -> outputs 0 immediately, sweep restarts.
- LEVEL=0: A writes 0x7 to addr 3, B reads addr 0 same cycle, READ_MODE=1 -> q_b = 0x7; ADDR_WIDTH upper bits ignored.
